// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations across E/M/W,
// raises stall when a source is not produced in time, and reports forward sources.
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [T_W-1:0]   d_tuse,
  input  logic [T_W-1:0]   d_tnew,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] d_rd,
  output logic             stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: stall=1 means the D record is not consumed this edge; D must hold it
  // and a bubble enters E. stall=0 means the D record enters E on this edge.

  typedef struct packed {
    logic           hit;
    logic [1:0]     code;
    logic [T_W-1:0] tnew;
  } lookup_t;

  logic [REG_W-1:0] r_e_dst, r_m_dst, r_w_dst;
  logic [T_W-1:0]   r_e_tnew, r_m_tnew, r_w_tnew;
  logic [CNT_W-1:0] r_stall_cnt;

  lookup_t w_rs_hit;
  lookup_t w_rt_hit;
  logic    w_stall_rs;
  logic    w_stall_rt;
  logic    w_stall;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - T_W'(1);
  endfunction

  // Youngest stage wins; register 0 never matches because src==0 is filtered first.
  function automatic lookup_t lookup(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] e_dst, input logic [T_W-1:0] e_tnew,
    input logic [REG_W-1:0] m_dst, input logic [T_W-1:0] m_tnew,
    input logic [REG_W-1:0] w_dst, input logic [T_W-1:0] w_tnew
  );
    lookup_t res;
    res = '0;
    if (src != '0) begin
      if (e_dst == src) begin
        res.hit  = 1'b1;
        res.code = 2'b01;
        res.tnew = e_tnew;
      end else if (m_dst == src) begin
        res.hit  = 1'b1;
        res.code = 2'b10;
        res.tnew = m_tnew;
      end else if (w_dst == src) begin
        res.hit  = 1'b1;
        res.code = 2'b11;
        res.tnew = w_tnew;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rs_hit   = lookup(d_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    w_rt_hit   = lookup(d_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    w_stall_rs = w_rs_hit.hit && (w_rs_hit.tnew > d_tuse);
    w_stall_rt = w_rt_hit.hit && (w_rt_hit.tnew > d_tuse);
    w_stall    = w_stall_rs || w_stall_rt;
  end

  assign stall     = w_stall;
  assign fwd_rs    = (w_rs_hit.hit && w_rs_hit.tnew == '0) ? w_rs_hit.code : 2'b00;
  assign fwd_rt    = (w_rt_hit.hit && w_rt_hit.tnew == '0) ? w_rt_hit.code : 2'b00;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_dst     <= '0;
      r_e_tnew    <= '0;
      r_m_dst     <= '0;
      r_m_tnew    <= '0;
      r_w_dst     <= '0;
      r_w_tnew    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_e_dst  <= '0;
        r_e_tnew <= '0;
      end else begin
        r_e_dst  <= d_rd;
        r_e_tnew <= d_tnew;
      end
      r_m_dst  <= r_e_dst;
      r_m_tnew <= sat_dec(r_e_tnew);
      r_w_dst  <= r_m_dst;
      r_w_tnew <= sat_dec(r_m_tnew);
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset corner sequence,
// and random stimulus against an issue-history reference model.
module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int T_W   = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [T_W-1:0]   d_tuse;
  logic [T_W-1:0]   d_tnew;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [REG_W-1:0] d_rd;
  logic             stall;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(.REG_W(REG_W), .T_W(T_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_tuse(d_tuse), .d_tnew(d_tnew), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: history of what entered E on each edge (dst, tnew at entry).
  // The instruction that entered k edges ago sits in stage k and has max(0, tnew-k) left.
  typedef struct { int dst; int tnew; } issue_t;
  issue_t hist[$];
  int     m_cnt;

  task automatic model_reset();
    issue_t empty;
    empty.dst  = 0;
    empty.tnew = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(empty);
    m_cnt = 0;
  endtask

  task automatic model_lookup(input int src, output int hit, output int code, output int rem);
    hit = 0; code = 0; rem = 0;
    if (src != 0) begin
      for (int k = 0; k < 3; k++) begin
        issue_t e;
        e = hist[hist.size() - 1 - k];
        if (hit == 0 && e.dst == src) begin
          hit  = 1;
          code = k + 1;
          rem  = (e.tnew > k) ? e.tnew - k : 0;
        end
      end
    end
  endtask

  task automatic model_eval(output int s, output int frs, output int frt);
    int h1, c1, r1, h2, c2, r2;
    model_lookup(int'(d_rs), h1, c1, r1);
    model_lookup(int'(d_rt), h2, c2, r2);
    s   = ((h1 != 0 && r1 > int'(d_tuse)) || (h2 != 0 && r2 > int'(d_tuse))) ? 1 : 0;
    frs = (h1 != 0 && r1 == 0) ? c1 : 0;
    frt = (h2 != 0 && r2 == 0) ? c2 : 0;
  endtask

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input int tuse, input int tnew, input int rs, input int rt, input int rd);
    d_tuse = T_W'(tuse);
    d_tnew = T_W'(tnew);
    d_rs   = REG_W'(rs);
    d_rt   = REG_W'(rt);
    d_rd   = REG_W'(rd);
  endtask

  // Advance one edge; the model sees what the D stage presented before the edge.
  task automatic tick();
    int s, frs, frt;
    issue_t n;
    model_eval(s, frs, frt);
    @(posedge clk);
    if (rst_n) begin
      n.dst  = (s != 0) ? 0 : int'(d_rd);
      n.tnew = (s != 0) ? 0 : int'(d_tnew);
      hist.push_back(n);
      void'(hist.pop_front());
      if (s != 0 && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    int s, frs, frt;
    model_eval(s, frs, frt);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".fwd_rs"}, 32'(fwd_rs), 32'(frs));
    chk({tag, ".fwd_rt"}, 32'(fwd_rt), 32'(frt));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  typedef struct {
    int tuse, tnew, rs, rt, rd;
    int s, frs, frt, cnt;
  } vec_t;
  vec_t vecs[20];

  initial begin
    // tuse tnew rs rt rd | stall fwd_rs fwd_rt cnt (sampled before the edge)
    vecs[0]  = '{2, 2, 0, 0, 1, 0, 0, 0, 0};  // lw $1
    vecs[1]  = '{1, 1, 1, 0, 3, 1, 0, 0, 0};  // addu uses $1 -> stall
    vecs[2]  = '{1, 1, 1, 0, 3, 0, 0, 0, 1};  // M.tnew=1, no stall, not ready
    vecs[3]  = '{1, 1, 0, 0, 2, 0, 0, 0, 1};  // addu $2
    vecs[4]  = '{0, 0, 2, 0, 0, 1, 0, 0, 1};  // beq on $2 -> stall
    vecs[5]  = '{0, 0, 2, 0, 0, 0, 2, 0, 2};  // forward from M
    vecs[6]  = '{2, 2, 0, 0, 0, 0, 0, 0, 2};  // producer with rd=0
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2};  // consumer rs=rt=0
    vecs[8]  = '{2, 1, 0, 0, 4, 0, 0, 0, 2};  // $4 tnew=1
    vecs[9]  = '{2, 1, 0, 0, 4, 0, 0, 0, 2};  // $4 again -> E{4,1} M{4,0}
    vecs[10] = '{0, 0, 4, 0, 0, 1, 0, 0, 2};  // E shadows ready M copy
    vecs[11] = '{0, 0, 4, 0, 0, 0, 2, 0, 3};
    vecs[12] = '{2, 0, 0, 0, 5, 0, 0, 0, 3};  // $5 ready at entry
    vecs[13] = '{2, 0, 4, 5, 0, 0, 0, 1, 3};  // rt from E
    vecs[14] = '{0, 0, 5, 5, 0, 0, 2, 2, 3};  // rs==rt from M
    vecs[15] = '{0, 0, 5, 5, 0, 0, 3, 3, 3};  // rs==rt from W
    vecs[16] = '{0, 2, 0, 0, 7, 0, 0, 0, 3};  // lw $7
    vecs[17] = '{0, 0, 0, 7, 0, 1, 0, 0, 3};  // back-to-back stall, rt
    vecs[18] = '{0, 0, 0, 7, 0, 1, 0, 0, 4};
    vecs[19] = '{0, 0, 0, 7, 0, 0, 0, 3, 5};  // W ready
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 1, 2, 3);
    model_reset();
    #3;
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.fwd_rs", 32'(fwd_rs), 32'd0);
    chk("reset.fwd_rt", 32'(fwd_rt), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].tuse, vecs[i].tnew, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      #2;
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].s));
      chk($sformatf("vec%0d.fwd_rs", i), 32'(fwd_rs), 32'(vecs[i].frs));
      chk($sformatf("vec%0d.fwd_rt", i), 32'(fwd_rt), 32'(vecs[i].frt));
      chk($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
      tick();
    end

    // reset asserted in the middle of a stall
    drive(2, 2, 0, 0, 1);
    #2;
    tick();
    drive(1, 1, 1, 0, 3);
    #2;
    chk("midrst.pre_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.fwd_rs", 32'(fwd_rs), 32'd0);
    chk("midrst.stall_cnt", 32'(stall_cnt), 32'd0);
    drive(0, 0, 1, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    tick();
    chk("postrst.stall", 32'(stall), 32'd0);
    chk("postrst.fwd_rs", 32'(fwd_rs), 32'd0);
    chk("postrst.fwd_rt", 32'(fwd_rt), 32'd0);
    chk("postrst.stall_cnt", 32'(stall_cnt), 32'd0);

    // random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      #2;
      chk_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_model($sformatf("rnd%0d.rst", n));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
